// File: rtl/pwm_fade_multi.sv
// -----------------------------------------------------------------------------
// pwm_fade_multi
//
// Multi-channel LED PWM generator with a shared period counter. Each channel
// has its own mode:
//   00 off, 01 steady on, 10 breathe (triangle fade engine), 11 manual duty.
// A channel's active duty is reloaded only at the period boundary, so a mode
// or duty change never produces a partial or glitched pulse.
//
// Optional build macro:
//   PWM_PHASE_STAGGER_EN - channel i compares against the count shifted by
//                          i*(PWM_INTERVAL/NUM_CH), spreading rising edges
//                          across the period. Duty reload stays at the global
//                          boundary. Undefined: all rising edges align at 0.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   en           global enable; low freezes counter and fade state, forces
//                pwm_out low
//   mode         per-channel mode, channel i at [2i+1:2i]
//   duty_in      per-channel manual duty, channel i at [W*i+W-1:W*i];
//                clamped to PWM_INTERVAL
//   pwm_out      registered PWM outputs (1 clk from count to pin)
//   period_start one-cycle pulse in the cycle after the counter holds 0
//   ramp_up      fade direction per channel, 1 = rising
// -----------------------------------------------------------------------------
module pwm_fade_multi #(
  parameter  int NUM_CH           = 3,
  parameter  int PWM_INTERVAL     = 1200,
  parameter  int STEPS            = 200,
  parameter  int PERIODS_PER_STEP = 10,
  localparam int W                = $clog2(PWM_INTERVAL + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic [W*NUM_CH-1:0]   duty_in,
  output logic [NUM_CH-1:0]     pwm_out,
  output logic                  period_start,
  output logic [NUM_CH-1:0]     ramp_up
);

  localparam int DUTY_STEP = PWM_INTERVAL / STEPS;
  localparam int SW        = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;

  if (PWM_INTERVAL % STEPS != 0) begin : g_bad_steps
    $error("pwm_fade_multi: PWM_INTERVAL must be an exact multiple of STEPS");
  end

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_MANUAL  = 2'b11
  } mode_t;

  typedef enum logic {
    FALL = 1'b0,
    RISE = 1'b1
  } fade_state_t;

  logic [W-1:0]             count;
  logic [SW-1:0]            step_cnt;
  logic                     boundary;
  logic                     step_tick;

  fade_state_t              state     [NUM_CH];
  fade_state_t              state_nxt [NUM_CH];
  logic [NUM_CH-1:0][W-1:0] fade_duty;
  logic [NUM_CH-1:0][W-1:0] fade_nxt;
  logic [NUM_CH-1:0][W-1:0] duty_src;
  logic [NUM_CH-1:0][W-1:0] active_duty;
  logic [NUM_CH-1:0][W-1:0] cmp_count;

  // Last cycle of a period while running; the step tick can only land here.
  assign boundary  = en && (count == W'(PWM_INTERVAL - 1));
  assign step_tick = boundary && (step_cnt == SW'(PERIODS_PER_STEP - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; this is what makes the active duty pick up the
  // pre-step fade value when boundary and step tick coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      step_cnt     <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= en && (count == '0);
      if (en) begin
        count <= boundary ? '0 : count + W'(1);
      end
      if (boundary) begin
        step_cnt <= step_tick ? '0 : step_cnt + SW'(1);
      end
    end
  end

  // Fade FSM next-state logic, one RISE/FALL machine per channel.
  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_nxt[i] = state[i];
      fade_nxt[i]  = fade_duty[i];
      if (en) begin
        if (mode_t'(mode[2*i +: 2]) != MODE_BREATHE) begin
          // Parked channels sit at the bottom, rising, so breathe always
          // starts from dark.
          fade_nxt[i]  = '0;
          state_nxt[i] = RISE;
        end else if (step_tick) begin
          unique case (state[i])
            RISE: begin
              fade_nxt[i] = fade_duty[i] + W'(DUTY_STEP);
              if (fade_nxt[i] == W'(PWM_INTERVAL)) state_nxt[i] = FALL;
            end
            FALL: begin
              fade_nxt[i] = fade_duty[i] - W'(DUTY_STEP);
              if (fade_nxt[i] == '0) state_nxt[i] = RISE;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) state[i] <= RISE;
      fade_duty <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) state[i] <= state_nxt[i];
      fade_duty <= fade_nxt;
    end
  end

  // Duty source selected by the current mode; latched only at the boundary.
  always_comb begin
    duty_src = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      unique case (mode_t'(mode[2*i +: 2]))
        MODE_OFF:     duty_src[i] = '0;
        MODE_ON:      duty_src[i] = W'(PWM_INTERVAL);
        MODE_BREATHE: duty_src[i] = fade_duty[i];
        MODE_MANUAL:  duty_src[i] = (duty_in[W*i +: W] > W'(PWM_INTERVAL)) ?
                                    W'(PWM_INTERVAL) : duty_in[W*i +: W];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_duty <= '0;
    end else if (boundary) begin
      active_duty <= duty_src;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
`ifdef PWM_PHASE_STAGGER_EN
    localparam int OFFSET = i * (PWM_INTERVAL / NUM_CH);
    logic [W:0] shifted;
    // One extra bit so the sum cannot wrap before the modulo subtract.
    assign shifted      = {1'b0, count} + (W+1)'(OFFSET);
    assign cmp_count[i] = (shifted >= (W+1)'(PWM_INTERVAL)) ?
                          W'(shifted - (W+1)'(PWM_INTERVAL)) : W'(shifted);
`else
    assign cmp_count[i] = count;
`endif
    assign ramp_up[i] = (state[i] == RISE);
  end

  // Duty 0 never satisfies the compare, duty PWM_INTERVAL always does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_out[i] <= en && (cmp_count[i] < active_duty[i]);
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_multi.sv
// -----------------------------------------------------------------------------
// tb_pwm_fade_multi
//
// Directed bench for pwm_fade_multi with PWM_INTERVAL=12, STEPS=4,
// PERIODS_PER_STEP=2, NUM_CH=3 (DUTY_STEP=3, W=4). Each measurement window
// starts at the period_start pulse and counts high cycles per channel over
// 12 cycles; expected values are hand-computed tables and constants.
// -----------------------------------------------------------------------------
module tb_pwm_fade_multi;

  localparam int NUM_CH = 3;
  localparam int PI     = 12;
  localparam int W      = 4;

  logic                clk;
  logic                rst;
  logic                en;
  logic [2*NUM_CH-1:0] mode;
  logic [W*NUM_CH-1:0] duty_in;
  logic [NUM_CH-1:0]   pwm_out;
  logic                period_start;
  logic [NUM_CH-1:0]   ramp_up;

  int checks = 0;
  int errors = 0;

  int          hi    [NUM_CH];
  int          first [NUM_CH];
  logic [2:0]  ramp_s;

  pwm_fade_multi #(
    .NUM_CH           (NUM_CH),
    .PWM_INTERVAL     (PI),
    .STEPS            (4),
    .PERIODS_PER_STEP (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .duty_in      (duty_in),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .ramp_up      (ramp_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where period_start is high.
  task automatic wait_start();
    int n;
    @(negedge clk);
    n = 1;
    while (!period_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!period_start) check("period_start_timeout", 0, 1);
  endtask

  // One full period window. At sample index chg_idx, duty_in takes chg_val
  // (sample j is taken while the counter register holds j+1).
  task automatic measure(input int chg_idx, input logic [W*NUM_CH-1:0] chg_val);
    wait_start();
    for (int c = 0; c < NUM_CH; c++) begin
      hi[c]    = 0;
      first[c] = -1;
    end
    ramp_s = ramp_up;
    for (int j = 0; j < PI; j++) begin
      if (j > 0) @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) begin
        if (pwm_out[c]) begin
          hi[c]++;
          if (first[c] < 0) first[c] = j;
        end
      end
      if (j == chg_idx) duty_in = chg_val;
    end
  endtask

  // ch0 breathe: high cycles per window p0..p20 and ramp_up[0] per window.
  int exp_duty [21] = '{0, 0, 0, 3, 3, 6, 6, 9, 9, 12, 12, 9, 9, 6, 6, 3, 3, 0, 0, 3, 3};

  initial begin
    int bad;
    int n;

    // ---------------- Phase A: on / off / manual ----------------
    rst     = 1'b1;
    en      = 1'b1;
    mode    = 6'b11_00_01;
    duty_in = {4'd5, 4'd0, 4'd0};
    repeat (3) @(negedge clk);
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_period_start", int'(period_start), 0);
    check("reset_ramp_up", int'(ramp_up), 7);
    rst = 1'b0;

    measure(-1, duty_in);              // p0: active duties still reset to 0
    check("p0_ch0", hi[0], 0);
    check("p0_ch2", hi[2], 0);

    measure(-1, duty_in);              // p1
    check("p1_ch0_on", hi[0], 12);
    check("p1_ch1_off", hi[1], 0);
    check("p1_ch2_manual5", hi[2], 5);
`ifndef PWM_PHASE_STAGGER_EN
    check("p1_ch2_first_high", first[2], 0);
`endif

    measure(3, {4'd8, 4'd0, 4'd0});    // change 5 -> 8 at count 4
    check("mid_change_keeps5", hi[2], 5);
    measure(-1, duty_in);
    check("next_period_8", hi[2], 8);

    // ---------------- en freeze at count 7 ----------------
    wait_start();                      // counter register now 1
    repeat (6) @(negedge clk);         // counter register now 7
    check("pre_freeze_ch2", int'(pwm_out[2]), 1);
    en  = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pwm_out != '0 || period_start) bad++;
    end
    check("freeze_outputs_low", bad, 0);
    en = 1'b1;
    @(negedge clk);                    // reflects count 7
    check("resume_ch2_cnt7", int'(pwm_out[2]), 1);
    check("resume_ch0_cnt7", int'(pwm_out[0]), 1);
    @(negedge clk);                    // reflects count 8
    check("resume_ch2_cnt8", int'(pwm_out[2]), 0);
    n = 2;
    while (!period_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("resume_cycles_to_start", n, 6);

    // ---------------- manual clamp ----------------
    duty_in = {4'd15, 4'd0, 4'd0};
    measure(-1, duty_in);
    check("clamp_ch2", hi[2], 12);
    check("clamp_ch0", hi[0], 12);
    check("clamp_ch1", hi[1], 0);

    // ---------------- Phase B: breathe on ch0 ----------------
    rst     = 1'b1;
    mode    = 6'b00_00_10;
    duty_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 21; p++) begin
      measure(-1, duty_in);
      check($sformatf("breathe_p%0d_duty", p), hi[0], exp_duty[p]);
      check($sformatf("breathe_p%0d_ramp", p), int'(ramp_s[0]), (p >= 8 && p < 16) ? 0 : 1);
    end

    // p21 has duty 6; reset in the middle of its high phase.
    wait_start();
    check("p21_high_c0", int'(pwm_out[0]), 1);
    repeat (2) @(negedge clk);
    check("p21_high_c2", int'(pwm_out[0]), 1);
    rst = 1'b1;
    #1;
    check("rst_async_pwm", int'(pwm_out), 0);
    check("rst_async_ramp", int'(ramp_up), 7);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 4; p++) begin
      measure(-1, duty_in);
      check($sformatf("restart_p%0d_duty", p), hi[0], exp_duty[p]);
      check($sformatf("restart_p%0d_ramp", p), int'(ramp_s[0]), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
